// File: rtl/alu_frame_rx_if.sv
// ---------------------------------------------------------------------------
// alu_frame_rx_if
// Bundles the serial command line and the decoded-result handshake of
// alu_frame_rx into one interface.
//
// Signals
//   sin        : serial command line, idle high (driven by the slave side)
//   out_ready  : consumer accepts the held result (driven by the slave side)
//   out_valid  : decoded command available
//   a_data     : operand A, 32 bits, reassembled MSB-first
//   b_data     : operand B, 32 bits, reassembled MSB-first
//   op         : 3-bit opcode from the command frame
//   err_data   : command arrived with a data-frame count other than 8
//   err_crc    : CRC4 mismatch
//   err_op     : opcode has OP[1] set (unsupported)
//   overrun    : one-cycle pulse, a finished command was dropped
//
// Handshake: a result transfers in the cycle where out_valid && out_ready are
// both high on a rising clk edge. While out_valid is high and out_ready is
// low, out_valid and every result/error output hold their value. out_valid
// never waits on out_ready to rise, and out_ready may be held high freely.
//
// Modports
//   master : the receiver (alu_frame_rx)
//   slave  : the line driver / result consumer
// ---------------------------------------------------------------------------
interface alu_frame_rx_if;
  logic        sin;
  logic        out_ready;
  logic        out_valid;
  logic [31:0] a_data;
  logic [31:0] b_data;
  logic [2:0]  op;
  logic        err_data;
  logic        err_crc;
  logic        err_op;
  logic        overrun;

  modport master (
    input  sin,
    input  out_ready,
    output out_valid,
    output a_data,
    output b_data,
    output op,
    output err_data,
    output err_crc,
    output err_op,
    output overrun
  );

  modport slave (
    output sin,
    output out_ready,
    input  out_valid,
    input  a_data,
    input  b_data,
    input  op,
    input  err_data,
    input  err_crc,
    input  err_op,
    input  overrun
  );
endinterface

// File: rtl/alu_frame_rx.sv
// ---------------------------------------------------------------------------
// alu_frame_rx
// Receives 11-bit serial frames (start 0, type, D7..D0, stop 1), one bit per
// clk. Eight data frames carry B[31:0] then A[31:0] MSB-first; a command frame
// carries {rsvd, OP[2:0], CRC[3:0]}. On a command frame the receiver checks
// the data count, a CRC4 (x^4+x+1, init 0) over {B, A, 1'b1, OP} and the
// opcode, then presents a registered result on a valid/ready handshake.
//
// Parameters
//   TIMEOUT_CYC : idle-line cycles after which a partial command is dropped
//                 (only active when ALU_FRAME_RX_TIMEOUT_EN is defined)
//
// Ports
//   clk       : single clock, rising edge
//   rst       : asynchronous, active-high reset
//   bus       : alu_frame_rx_if.master (sin, out_ready, result outputs)
//   dbg_state : current frame FSM state (0 IDLE, 1 TYPE, 2 DATA, 3 STOP)
//
// Build option
//   ALU_FRAME_RX_TIMEOUT_EN : when defined, TIMEOUT_CYC consecutive idle-high
//   cycles in IDLE with partial data clear the data counter and CRC state.
// ---------------------------------------------------------------------------
module alu_frame_rx #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic         clk,
  input  logic         rst,
  alu_frame_rx_if.master bus,
  output logic [1:0]   dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_TYPE = 2'd1,
    S_DATA = 2'd2,
    S_STOP = 2'd3
  } state_t;

  // One serial CRC4 step, MSB-first, polynomial x^4+x+1.
  function automatic logic [3:0] crc_step(input logic [3:0] c, input logic b);
    logic fb;
    fb = c[3] ^ b;
    return {c[2], c[1], c[0] ^ fb, fb};
  endfunction

  state_t      state_q, state_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic        type_q, type_d;
  logic [7:0]  byte_q, byte_d;
  logic [63:0] shreg_q, shreg_d;
  logic [3:0]  dcnt_q, dcnt_d;
  logic [3:0]  crc_q, crc_d;
  logic        brk_q, brk_d;     // bad stop seen: wait for line high
  logic        valid_q, valid_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  op_q, op_d;
  logic        errd_q, errd_d;
  logic        errc_q, errc_d;
  logic        erro_q, erro_d;
  logic        ovr_q, ovr_d;

`ifdef ALU_FRAME_RX_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] to_q, to_d;
`else
  // Timeout disabled: the parameter stays only so instantiations are
  // identical in both builds.
  if (TIMEOUT_CYC < 0) begin : g_timeout_unused
  end
`endif

  // -------------------------------------------------------------------------
  // FSM state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // -------------------------------------------------------------------------
  // FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (!bus.sin && !brk_q) state_d = S_TYPE;
      S_TYPE: state_d = S_DATA;
      S_DATA: if (bit_cnt_q == 3'd7) state_d = S_STOP;
      S_STOP: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // FSM outputs / datapath next values
  // -------------------------------------------------------------------------
  always_comb begin
    bit_cnt_d = bit_cnt_q;
    type_d    = type_q;
    byte_d    = byte_q;
    shreg_d   = shreg_q;
    dcnt_d    = dcnt_q;
    crc_d     = crc_q;
    brk_d     = brk_q;
    valid_d   = valid_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    errd_d    = errd_q;
    errc_d    = errc_q;
    erro_d    = erro_q;
    ovr_d     = 1'b0;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
    to_d      = '0;
`endif

    // Acceptance first; a command finishing this same cycle overrides it.
    if (valid_q && bus.out_ready) valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.sin) brk_d = 1'b0;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
        if (bus.sin && dcnt_q != 4'd0) begin
          if (to_q == TW'(TIMEOUT_CYC - 1)) begin
            dcnt_d = 4'd0;
            crc_d  = 4'd0;
          end else begin
            to_d = to_q + TW'(1);
          end
        end
`endif
      end

      S_TYPE: begin
        type_d    = bus.sin;
        bit_cnt_d = 3'd0;
      end

      S_DATA: begin
        byte_d    = {byte_q[6:0], bus.sin};
        bit_cnt_d = bit_cnt_q + 3'd1;
        if (!type_q) begin
          crc_d = crc_step(crc_q, bus.sin);
        end else if (bit_cnt_q == 3'd0) begin
          // The reserved bit slot is where the fixed '1' enters the CRC.
          crc_d = crc_step(crc_q, 1'b1);
        end else if (bit_cnt_q <= 3'd3) begin
          crc_d = crc_step(crc_q, bus.sin);   // OP[2:0]
        end
      end

      S_STOP: begin
        if (!bus.sin) begin
          // Broken frame: drop the whole partial command.
          dcnt_d  = 4'd0;
          crc_d   = 4'd0;
          shreg_d = '0;
          brk_d   = 1'b1;
        end else if (!type_q) begin
          shreg_d = {shreg_q[55:0], byte_q};
          if (dcnt_q != 4'd9) dcnt_d = dcnt_q + 4'd1;
        end else begin
          dcnt_d = 4'd0;
          crc_d  = 4'd0;
          if (!valid_q || bus.out_ready) begin
            valid_d = 1'b1;
            errd_d  = 1'b0;
            errc_d  = 1'b0;
            erro_d  = 1'b0;
            if (dcnt_q != 4'd8) begin
              errd_d = 1'b1;
              a_d    = '0;
              b_d    = '0;
              op_d   = '0;
            end else begin
              b_d  = shreg_q[63:32];
              a_d  = shreg_q[31:0];
              op_d = byte_q[6:4];
              if (crc_q != byte_q[3:0]) errc_d = 1'b1;
              else if (byte_q[5])       erro_d = 1'b1;
            end
          end else begin
            ovr_d = 1'b1;
          end
        end
      end

      default: ;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bit_cnt_q <= '0;
      type_q    <= 1'b0;
      byte_q    <= '0;
      shreg_q   <= '0;
      dcnt_q    <= '0;
      crc_q     <= '0;
      brk_q     <= 1'b0;
      valid_q   <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      errd_q    <= 1'b0;
      errc_q    <= 1'b0;
      erro_q    <= 1'b0;
      ovr_q     <= 1'b0;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
      to_q      <= '0;
`endif
    end else begin
      bit_cnt_q <= bit_cnt_d;
      type_q    <= type_d;
      byte_q    <= byte_d;
      shreg_q   <= shreg_d;
      dcnt_q    <= dcnt_d;
      crc_q     <= crc_d;
      brk_q     <= brk_d;
      valid_q   <= valid_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      errd_q    <= errd_d;
      errc_q    <= errc_d;
      erro_q    <= erro_d;
      ovr_q     <= ovr_d;
`ifdef ALU_FRAME_RX_TIMEOUT_EN
      to_q      <= to_d;
`endif
    end
  end

  assign bus.out_valid = valid_q;
  assign bus.a_data    = a_q;
  assign bus.b_data    = b_q;
  assign bus.op        = op_q;
  assign bus.err_data  = errd_q;
  assign bus.err_crc   = errc_q;
  assign bus.err_op    = erro_q;
  assign bus.overrun   = ovr_q;
  assign dbg_state     = state_q;

endmodule

// File: tb/tb_alu_frame_rx.sv
// ---------------------------------------------------------------------------
// tb_alu_frame_rx
// Directed bench for alu_frame_rx. Inputs change on the falling edge; outputs
// are sampled on the falling edge, half a cycle away from the sampling edge.
// Expected CRC nibbles are worked out by hand:
//   B=0,A=0,OP=000 -> 0xB   B=0,A=0,OP=010 -> 0xD   B=0,A=0,OP=100 -> 0x7
//   B=0,A=1,OP=000 -> 0xE   B=0,A=1,OP=001 -> 0xD
// ---------------------------------------------------------------------------
module tb_alu_frame_rx;

  logic       clk;
  logic       rst;
  logic [1:0] dbg_state;
  int         errors;
  int         checks;

  alu_frame_rx_if bus_if ();

  alu_frame_rx #(.TIMEOUT_CYC(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus_if),
    .dbg_state (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_res(input string tag, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [2:0] op, input logic [2:0] errs);
    check({tag, ".valid"}, 64'(bus_if.out_valid), 64'(v));
    check({tag, ".a"},     64'(bus_if.a_data), 64'(a));
    check({tag, ".b"},     64'(bus_if.b_data), 64'(b));
    check({tag, ".op"},    64'(bus_if.op), 64'(op));
    check({tag, ".errs"},  64'({bus_if.err_data, bus_if.err_crc, bus_if.err_op}), 64'(errs));
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic send_bit(input logic b);
    bus_if.sin = b;
    @(negedge clk);
  endtask

  task automatic send_frame_bits(input logic typ, input logic [7:0] byt);
    send_bit(1'b0);
    send_bit(typ);
    for (int i = 7; i >= 0; i--) send_bit(byt[i]);
  endtask

  task automatic send_frame(input logic typ, input logic [7:0] byt);
    send_frame_bits(typ, byt);
    send_bit(1'b1);
  endtask

  task automatic send_data8(input logic [31:0] b, input logic [31:0] a);
    for (int i = 0; i < 4; i++) send_frame(1'b0, b[31-8*i -: 8]);
    for (int i = 0; i < 4; i++) send_frame(1'b0, a[31-8*i -: 8]);
  endtask

  task automatic send_cmd(input logic [31:0] b, input logic [31:0] a, input logic [7:0] cmd);
    send_data8(b, a);
    send_frame(1'b1, cmd);
  endtask

  task automatic idle(input int n);
    bus_if.sin = 1'b1;
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus_if.sin = 1'b1;
    bus_if.out_ready = 1'b1;
    tick();
    tick();
    check_res("reset", 1'b0, 32'h0, 32'h0, 3'd0, 3'b000);
    check("reset.overrun", 64'(bus_if.overrun), 64'd0);
    check("reset.state", 64'(dbg_state), 64'd0);
    rst = 1'b0;
    idle(3);

    // clean all-zero command, accepted immediately
    send_cmd(32'h0, 32'h0, 8'h0B);
    check_res("zero_ok", 1'b1, 32'h0, 32'h0, 3'd0, 3'b000);
    tick();
    check("zero_ok.drop", 64'(bus_if.out_valid), 64'd0);

    // wrong CRC
    send_cmd(32'h0, 32'h0, 8'h0C);
    check_res("bad_crc", 1'b1, 32'h0, 32'h0, 3'd0, 3'b010);
    tick();

    // A=1, OP=001
    send_cmd(32'h0, 32'h1, 8'h1D);
    check_res("a1_op1", 1'b1, 32'h1, 32'h0, 3'd1, 3'b000);
    tick();

    // OP=100 is legal (OP[1]=0)
    send_cmd(32'h0, 32'h0, 8'h47);
    check_res("op4", 1'b1, 32'h0, 32'h0, 3'd4, 3'b000);
    tick();

    // reserved bit set is ignored
    send_cmd(32'h0, 32'h1, 8'h8E);
    check_res("rsvd", 1'b1, 32'h1, 32'h0, 3'd0, 3'b000);
    tick();

    // seven data frames -> err_data, then a clean command
    for (int i = 1; i <= 7; i++) send_frame(1'b0, 8'(8'h11 * i));
    send_frame(1'b1, 8'h3F);
    check_res("seven", 1'b1, 32'h0, 32'h0, 3'd0, 3'b100);
    tick();
    send_cmd(32'h0, 32'h1, 8'h1D);
    check_res("after_seven", 1'b1, 32'h1, 32'h0, 3'd1, 3'b000);
    tick();

    // nine data frames -> err_data
    for (int i = 0; i < 9; i++) send_frame(1'b0, 8'h00);
    send_frame(1'b1, 8'h0B);
    check_res("nine", 1'b1, 32'h0, 32'h0, 3'd0, 3'b100);
    tick();

    // err_op held with out_ready low, then overrun
    bus_if.out_ready = 1'b0;
    send_cmd(32'h0, 32'h0, 8'h2D);
    check_res("errop", 1'b1, 32'h0, 32'h0, 3'd2, 3'b001);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("hold", 64'({bus_if.out_valid, bus_if.op, bus_if.err_data,
                        bus_if.err_crc, bus_if.err_op}), 64'({1'b1, 3'd2, 3'b001}));
    end
    send_cmd(32'h0, 32'h0, 8'h0B);
    check("overrun.pulse", 64'(bus_if.overrun), 64'd1);
    check_res("overrun.keep", 1'b1, 32'h0, 32'h0, 3'd2, 3'b001);
    tick();
    check("overrun.clear", 64'(bus_if.overrun), 64'd0);

    // acceptance in the same cycle a new command completes
    send_data8(32'h0, 32'h1);
    send_frame_bits(1'b1, 8'h1D);
    bus_if.out_ready = 1'b1;
    send_bit(1'b1);
    check_res("same_cycle", 1'b1, 32'h1, 32'h0, 3'd1, 3'b000);
    check("same_cycle.overrun", 64'(bus_if.overrun), 64'd0);
    tick();
    check("same_cycle.drop", 64'(bus_if.out_valid), 64'd0);

    // broken stop bit discards the partial command
    for (int i = 0; i < 3; i++) send_frame(1'b0, 8'h55);
    send_frame_bits(1'b0, 8'hAA);
    send_bit(1'b0);
    idle(2);
    check("badstop.quiet", 64'(bus_if.out_valid), 64'd0);
    send_cmd(32'h0, 32'h0, 8'h0B);
    check_res("badstop.next", 1'b1, 32'h0, 32'h0, 3'd0, 3'b000);
    tick();

    // reset mid-command clears held result and partial data
    bus_if.out_ready = 1'b0;
    send_cmd(32'h0, 32'h1, 8'h1D);
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'hFF);
    send_bit(1'b0);
    send_bit(1'b0);
    send_bit(1'b1);
    rst = 1'b1;
    #1;
    check_res("midrst", 1'b0, 32'h0, 32'h0, 3'd0, 3'b000);
    check("midrst.state", 64'(dbg_state), 64'd0);
    bus_if.sin = 1'b1;
    tick();
    rst = 1'b0;
    bus_if.out_ready = 1'b1;
    idle(2);
    send_cmd(32'h0, 32'h0, 8'h0B);
    check_res("after_rst", 1'b1, 32'h0, 32'h0, 3'd0, 3'b000);
    tick();

    // partial data followed by a long idle line
    for (int i = 0; i < 4; i++) send_frame(1'b0, 8'h00);
    idle(64);
    send_cmd(32'h0, 32'h0, 8'h0B);
`ifdef ALU_FRAME_RX_TIMEOUT_EN
    check_res("timeout", 1'b1, 32'h0, 32'h0, 3'd0, 3'b000);
`else
    check_res("no_timeout", 1'b1, 32'h0, 32'h0, 3'd0, 3'b100);
`endif
    tick();
    check("final.drop", 64'(bus_if.out_valid), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/alu_frame_rx.md
ALU_FRAME_RX -- requirements
Module: alu_frame_rx

Interface
REQ-001 Parameter: TIMEOUT_CYC, 64, idle-line cycles after which a partial command is discarded (used only with ALU_FRAME_RX_TIMEOUT_EN).
REQ-002 clk  in  1  single clock; all sampling and state updates on rising edge.
REQ-003 rst  in  1  asynchronous, active-high reset.
REQ-004 sin  in  1  serial command line; idle high.
REQ-005 out_ready  in  1  consumer accepts the held result.
REQ-006 out_valid  out  1  decoded command available.
REQ-007 a_data, b_data  out  32 each  operands, MSB-first reassembled.
REQ-008 op  out  3  opcode from command frame.
REQ-009 err_data, err_crc, err_op  out  1 each  error flags, valid with out_valid.
REQ-010 overrun  out  1  one-cycle pulse: a command completed while out_valid && !out_ready; that command is dropped.

Function
REQ-011 Frame = 11 bits sampled one per clk: start(0), type(0 data / 1 cmd), D7..D0, stop(1).
REQ-012 Frame FSM states IDLE, TYPE, DATA (8 bits, 3-bit counter), STOP; IDLE->TYPE on sin==0; STOP->IDLE unconditionally; a new start bit is accepted in the cycle right after STOP (back-to-back frames).
REQ-013 Stop bit sampled 0: frame discarded, whole partial command discarded, FSM returns to IDLE (line must go high before next start).
REQ-014 Data frames shift into a 64-bit register; first four bytes form b_data[31:0], next four a_data[31:0]; data-frame counter saturates at 9.
REQ-015 Command byte = {rsvd, OP[2:0], CRC[3:0]}; rsvd ignored.
REQ-016 CRC4: polynomial x^4+x+1, init 0, no final XOR, serial MSB-first over 68 bits {B[31:0], A[31:0], 1'b1, OP[2:0]}; B[31] first, OP[0] last.
REQ-017 On command frame: result = err_data if data count != 8; else err_crc if CRC mismatch; else err_op if OP[1]==1; else no error; exactly one flag or none set.
REQ-018 err_data result: a_data, b_data, op driven 0.
REQ-019 Result registered; out_valid rises the cycle after the command stop bit is sampled.
REQ-020 out_valid and all result outputs hold stable until the cycle out_valid && out_ready; out_valid drops the next cycle unless a new result loads in the same cycle.
REQ-021 Command completing in the same cycle as acceptance loads normally (no overrun).
REQ-022 After any command frame, data counter and CRC state clear for the next command.

Reset
REQ-023 rst asserted: FSM IDLE, counters 0, shift register 0, out_valid 0, a_data/b_data 0, op 0, all error flags 0, overrun 0, effective immediately.
REQ-024 Reset mid-frame or mid-command discards all partial data; first command after release is decoded normally.

Configuration
REQ-025 Macro ALU_FRAME_RX_TIMEOUT_EN defined: in IDLE with data count > 0, TIMEOUT_CYC consecutive sin==1 cycles clear the data counter and CRC state; counter restarts on each start bit.
REQ-026 Macro undefined: no timeout; partial data persists indefinitely until a command frame (then err_data if count != 8).

Verification
REQ-027 B=0, A=0, cmd byte 0x0B, out_ready=1 -> out_valid one cycle, op=000, no error flags, a_data=b_data=0.
REQ-028 B=0, A=0, cmd byte 0x0C (CRC 0xC) -> err_crc=1, err_data=0, err_op=0.
REQ-029 Seven data frames then any cmd byte -> err_data=1, a_data=b_data=op=0; following valid command decodes cleanly.
REQ-030 Valid frame with OP=010 and correct CRC -> err_op=1 only; out_ready held 0 for 20 cycles -> outputs stable; second full command meanwhile -> overrun pulse, first result retained.
REQ-031 rst pulse after 4 data frames, then full valid command (B=0, A=0, 0x0B) -> clean decode, no error.
REQ-032 With ALU_FRAME_RX_TIMEOUT_EN: 4 data frames, 64 idle cycles, then 8 data frames + correct cmd -> no error; without the macro same stimulus -> err_data=1.
